display_scan_mux: RTL

//   Time-multiplexed N-digit display driver for the alarm clock's 7-segment front end.

---
 rtl/display_scan_mux_pkg.sv | 17 +
 rtl/scan_tick_gen.sv | 32 +++
 rtl/display_scan_mux.sv | 103 ++++++++++
 3 files changed

// File: rtl/display_scan_mux_pkg.sv
// display_pkg: constants and helpers shared by the display scan path and the
// clock top.
//   sel_width(n)        : index width for n items, never less than 1
//   ANODE_OFF           : anode drive level for a dark digit (active-low)
//   SCAN_DIV_DEFAULT    : clk cycles per digit slot
//   BLINK_SCANS_DEFAULT : full scans per blink half-period
package display_pkg;

  localparam int   SCAN_DIV_DEFAULT    = 50000;
  localparam int   BLINK_SCANS_DEFAULT = 250;
  localparam logic ANODE_OFF           = 1'b1;

  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: slot prescaler. Counts 0..DIV-1 while en is high and holds
// while en is low.
//   clk, rst_n : clock, async active-low reset
//   en         : count enable
//   tick       : high during the last cycle of a slot (count advances to 0)
//   slot_start : high while the count is 0 (first cycle of a slot)
module scan_tick_gen
  import display_pkg::*;
#(
  parameter int DIV = SCAN_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick,
  output logic slot_start
);

  localparam int CW = sel_width(DIV);

  logic [CW-1:0] cnt;

  assign tick       = en && (cnt == CW'(DIV - 1));
  assign slot_start = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else if (en)   cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed N-digit 7-segment scan driver.
// Rotates one active-low anode across NUM_DIGITS slots of SCAN_DIV cycles.
// The first cycle of every slot is dark, which suppresses ghosting. Digits can
// be blanked permanently or blinked at a rate of BLINK_SCANS scans per half-period.
//   clk, rst_n : clock, async active-low reset
//   en         : 1 = scanning; 0 = counters hold and the display is dark
//   digits_in  : packed digit codes, digit i at [i*DIGIT_W +: DIGIT_W]
//   dp_in      : decimal point per digit
//   blank_mask : 1 = digit always dark
//   blink_mask : 1 = digit dark during the blink-off phase
//   digit_out  : code of the driven digit (0 when dark)
//   dp_out     : decimal point of the driven digit (0 when dark)
//   anode_n    : one-cold anode enable, all 1s = dark
//   digit_sel  : current slot index
//   scan_wrap  : one-cycle pulse after the slot NUM_DIGITS-1 -> 0 advance
module display_scan_mux
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = 4,
  parameter int SCAN_DIV    = SCAN_DIV_DEFAULT,
  parameter int BLINK_SCANS = BLINK_SCANS_DEFAULT,
  localparam int SEL_W      = sel_width(NUM_DIGITS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  output logic [DIGIT_W-1:0]            digit_out,
  output logic                          dp_out,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic [SEL_W-1:0]              digit_sel,
  output logic                          scan_wrap
);

  localparam int BW = sel_width(BLINK_SCANS);

  logic          tick, slot_start, wrap_tick, vis;
  logic          blink_phase;
  logic [BW-1:0] blink_cnt;

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .tick       (tick),
    .slot_start (slot_start)
  );

  // Wrap is explicit at NUM_DIGITS-1 so non-power-of-2 counts skip unused codes.
  assign wrap_tick = tick && (digit_sel == SEL_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel <= '0;
      scan_wrap <= 1'b0;
    end else begin
      scan_wrap <= wrap_tick;
      if (wrap_tick) digit_sel <= '0;
      else if (tick) digit_sel <= digit_sel + SEL_W'(1);
    end
  end

  // The blink counter steps on the same edge that raises scan_wrap. A blink
  // terminal count coinciding with the scan wrap therefore toggles on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap_tick) begin
      if (blink_cnt == BW'(BLINK_SCANS - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign vis = !blank_mask[digit_sel] && !(blink_phase && blink_mask[digit_sel]);

  // Outputs are registered from the current slot state, so there is one cycle
  // of latency and no slot-boundary sampling of the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_n   <= {NUM_DIGITS{ANODE_OFF}};
      digit_out <= '0;
      dp_out    <= 1'b0;
    end else if (en && vis && !slot_start) begin
      anode_n   <= ~(NUM_DIGITS'(1) << digit_sel);
      digit_out <= digits_in[digit_sel*DIGIT_W +: DIGIT_W];
      dp_out    <= dp_in[digit_sel];
    end else begin
      anode_n   <= {NUM_DIGITS{ANODE_OFF}};
      digit_out <= '0;
      dp_out    <= 1'b0;
    end
  end

endmodule
